// File: rtl/zxtres_joy_pkg.sv
// Shared types, bit positions and the per-port pad decode for the ZXTres joystick reader.
package zxtres_joy_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSelSettle,
        StLoad,
        StShift,
        StUpdate
    } joy_state_e;

    // Bit positions inside a 6-bit port field {U,D,L,R,F1,F2}
    localparam int unsigned POS_U  = 5;
    localparam int unsigned POS_D  = 4;
    localparam int unsigned POS_L  = 3;
    localparam int unsigned POS_R  = 2;
    localparam int unsigned POS_F1 = 1;
    localparam int unsigned POS_F2 = 0;

    localparam int unsigned PORT0_BASE = 15;
    localparam int unsigned PORT1_BASE = 7;

    localparam int unsigned PAD_I      = 0;
    localparam int unsigned PAD_II     = 1;
    localparam int unsigned PAD_SELECT = 2;
    localparam int unsigned PAD_RUN    = 3;
    localparam int unsigned PAD_UP     = 4;
    localparam int unsigned PAD_RIGHT  = 5;
    localparam int unsigned PAD_DOWN   = 6;
    localparam int unsigned PAD_LEFT   = 7;

    typedef struct packed {
        logic       md;
        logic [7:0] pad;
    } pad_result_t;

    // h: raw field sampled with SEL high, l: raw field sampled with SEL low (both active-low).
    function automatic pad_result_t decode_port(input logic [5:0] i_h, input logic [5:0] i_l);
        pad_result_t w_res;
        logic [5:0]  w_h;
        logic [5:0]  w_l;
        w_h = ~i_h;
        w_l = ~i_l;
        w_res.md               = w_l[POS_L] & w_l[POS_R];
        w_res.pad              = '0;
        w_res.pad[PAD_I]       = w_h[POS_F1];
        w_res.pad[PAD_II]      = w_h[POS_F2];
        w_res.pad[PAD_UP]      = w_h[POS_U];
        w_res.pad[PAD_RIGHT]   = w_h[POS_R];
        w_res.pad[PAD_DOWN]    = w_h[POS_D];
        w_res.pad[PAD_LEFT]    = w_h[POS_L];
        if (w_res.md) begin
            w_res.pad[PAD_SELECT] = w_l[POS_F1];
            w_res.pad[PAD_RUN]    = w_l[POS_F2];
        end
        return w_res;
    endfunction

endpackage

// File: rtl/joy_bit_timer.sv
// Half-bit prescaler: strobes once every CLK_DIV cycles, restartable to align with a new state.
module joy_bit_timer #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    output logic o_strobe
);
    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_strobe = (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_restart || o_strobe) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/zxtres_joy_reader.sv
// Scans the ZXTres 74HC165 joystick chain twice per frame (SEL high, then low) and
// publishes both decoded pad words atomically with a one-cycle valid pulse.
module zxtres_joy_reader
    import zxtres_joy_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 25,
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned SETTLE   = 100
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       JOY_DATA,
    output logic       JOY_CLK,
    output logic       JOY_LOAD,
    output logic       JOY_SEL,
    output logic [7:0] joy0,
    output logic [7:0] joy1,
    output logic       joy_valid,
    output logic       md0,
    output logic       md1
);
    localparam int unsigned PHASE_LEN = SETTLE + 34 * CLK_DIV;
    localparam int unsigned SCAN_LEN  = 2 * PHASE_LEN + 1;
    localparam int unsigned SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned SETTLE_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SCAN_W-1:0]   SCAN_LAST   = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);
    localparam logic [4:0]          HALF_LAST   = 5'd31;

    joy_state_e          r_state;
    joy_state_e          w_state_d;
    logic                r_phase;
    logic                w_phase_d;
    logic [SCAN_W-1:0]   r_scan_cnt;
    logic [SETTLE_W-1:0] r_settle_cnt;
    logic [4:0]          r_half;
    logic [15:0]         r_shift;
    logic [15:0]         w_shift_d;
    logic [15:0]         r_hi;
    logic                r_jclk;
    logic                r_load;
    logic                r_sel;
    logic                w_jclk_d;
    logic                w_load_d;
    logic                w_sel_d;
    logic                w_tick;
    logic                w_strobe;
    logic                w_restart;
    logic                w_sample;
    logic [7:0]          r_joy0;
    logic [7:0]          r_joy1;
    logic                r_md0;
    logic                r_md1;
    logic                r_valid;
    pad_result_t         w_p0;
    pad_result_t         w_p1;

    assign w_tick = (r_scan_cnt == SCAN_LAST);

    joy_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .i_clk     (CLOCK_50),
        .i_rst     (RESET),
        .i_restart (w_restart),
        .o_strobe  (w_strobe)
    );

    always_comb begin
        w_state_d = r_state;
        w_phase_d = r_phase;
        unique case (r_state)
            StIdle: begin
                if (w_tick) begin
                    w_state_d = StSelSettle;
                    w_phase_d = 1'b0;
                end
            end
            StSelSettle: begin
                if (r_settle_cnt == SETTLE_LAST) w_state_d = StLoad;
            end
            StLoad: begin
                if (w_strobe && r_half[0]) w_state_d = StShift;
            end
            StShift: begin
                if (w_strobe && (r_half == HALF_LAST)) begin
                    if (r_phase) begin
                        w_state_d = StUpdate;
                    end else begin
                        w_state_d = StSelSettle;
                        w_phase_d = 1'b1;
                    end
                end
            end
            StUpdate: w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase

        w_restart = (w_state_d != r_state) && ((w_state_d == StLoad) || (w_state_d == StShift));
        // Sample on the last low cycle of each bit, just before JOY_CLK rises
        w_sample  = (r_state == StShift) && w_strobe && !r_half[0];
        w_shift_d = w_sample ? {r_shift[14:0], JOY_DATA} : r_shift;

        // Pins are registered from the next state so they never glitch
        w_sel_d  = !(w_phase_d && ((w_state_d == StSelSettle) || (w_state_d == StLoad) ||
                                   (w_state_d == StShift)));
        w_load_d = (w_state_d != StLoad);
        w_jclk_d = 1'b1;
        if (w_state_d == StShift) begin
            w_jclk_d = (r_state == StShift) ? (r_jclk ^ w_strobe) : 1'b0;
        end
    end

    assign w_p0 = decode_port(r_hi[PORT0_BASE -: 6], r_shift[PORT0_BASE -: 6]);
    assign w_p1 = decode_port(r_hi[PORT1_BASE -: 6], r_shift[PORT1_BASE -: 6]);

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_state      <= StIdle;
            r_phase      <= 1'b0;
            r_scan_cnt   <= '0;
            r_settle_cnt <= '0;
            r_half       <= '0;
            r_shift      <= '0;
            r_hi         <= '0;
            r_jclk       <= 1'b1;
            r_load       <= 1'b1;
            r_sel        <= 1'b1;
            r_joy0       <= '0;
            r_joy1       <= '0;
            r_md0        <= 1'b0;
            r_md1        <= 1'b0;
            r_valid      <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_phase    <= w_phase_d;
            r_scan_cnt <= w_tick ? '0 : r_scan_cnt + 1'b1;
            if ((r_state == StSelSettle) && (w_state_d == StSelSettle)) begin
                r_settle_cnt <= r_settle_cnt + 1'b1;
            end else begin
                r_settle_cnt <= '0;
            end
            if (w_restart) begin
                r_half <= '0;
            end else if (w_strobe) begin
                r_half <= r_half + 1'b1;
            end
            r_shift <= w_shift_d;
            if ((r_state == StShift) && (w_state_d != StShift) && !r_phase) begin
                r_hi <= w_shift_d;
            end
            r_jclk  <= w_jclk_d;
            r_load  <= w_load_d;
            r_sel   <= w_sel_d;
            r_valid <= (r_state == StUpdate);
            if (r_state == StUpdate) begin
                r_joy0 <= w_p0.pad;
                r_joy1 <= w_p1.pad;
                r_md0  <= w_p0.md;
                r_md1  <= w_p1.md;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        assert (SCAN_DIV > SCAN_LEN)
        else $error("SCAN_DIV must exceed the scan length");
    end

    assign JOY_CLK   = r_jclk;
    assign JOY_LOAD  = r_load;
    assign JOY_SEL   = r_sel;
    assign joy0      = r_joy0;
    assign joy1      = r_joy1;
    assign md0       = r_md0;
    assign md1       = r_md1;
    assign joy_valid = r_valid;

endmodule

// File: tb/tb_zxtres_joy_reader.sv
// Bench for zxtres_joy_reader: behavioural 74HC165 chain plus a scoreboard of expected pad words.
module tb_zxtres_joy_reader;

    localparam int CD       = 4;
    localparam int STL      = 10;
    localparam int SD       = 2000;
    localparam int PH       = STL + 34 * CD;
    localparam int SCAN_LEN = 2 * PH + 1;
    localparam int BUDGET   = 2 * SD + SCAN_LEN;

    typedef struct packed {
        logic [7:0] j0;
        logic [7:0] j1;
        logic       m0;
        logic       m1;
    } exp_t;

    logic        CLOCK_50 = 1'b0;
    logic        RESET    = 1'b1;
    logic        JOY_DATA;
    logic        JOY_CLK;
    logic        JOY_LOAD;
    logic        JOY_SEL;
    logic [7:0]  joy0;
    logic [7:0]  joy1;
    logic        joy_valid;
    logic        md0;
    logic        md1;

    logic [15:0] word_h = 16'hFFFF;
    logic [15:0] word_l = 16'hFFFF;
    logic [15:0] chain  = 16'hFFFF;
    int          cyc    = 0;
    int          rel_cyc = 0;
    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        sb_q[$];

    zxtres_joy_reader #(
        .CLK_DIV  (CD),
        .SCAN_DIV (SD),
        .SETTLE   (STL)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET     (RESET),
        .JOY_DATA  (JOY_DATA),
        .JOY_CLK   (JOY_CLK),
        .JOY_LOAD  (JOY_LOAD),
        .JOY_SEL   (JOY_SEL),
        .joy0      (joy0),
        .joy1      (joy1),
        .joy_valid (joy_valid),
        .md0       (md0),
        .md1       (md1)
    );

    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // 74HC165 chain: parallel load on LOAD low, shift toward bit 15 on JOY_CLK rise
    always @(negedge JOY_LOAD or posedge JOY_CLK) begin
        if (!JOY_LOAD) chain <= JOY_SEL ? word_h : word_l;
        else           chain <= {chain[14:0], 1'b1};
    end
    assign JOY_DATA = chain[15];

    function automatic logic [8:0] model_port(input logic [15:0] h, input logic [15:0] l,
                                              input int base);
        logic u, d, lf, rt, f1, f2, md;
        u  = ~h[base];
        d  = ~h[base - 1];
        lf = ~h[base - 2];
        rt = ~h[base - 3];
        f1 = ~h[base - 4];
        f2 = ~h[base - 5];
        md = ~l[base - 2] & ~l[base - 3];
        return {md, lf, d, rt, u, md & ~l[base - 5], md & ~l[base - 4], f2, f1};
    endfunction

    task automatic push_model();
        logic [8:0] m0, m1;
        m0 = model_port(word_h, word_l, 15);
        m1 = model_port(word_h, word_l, 7);
        sb_q.push_back({m0[7:0], m1[7:0], m0[8], m1[8]});
    endtask

    task automatic wait_valid(output bit seen, output int t);
        seen = 1'b0;
        t    = -1;
        for (int n = 0; n < BUDGET && !seen; n++) begin
            @(negedge CLOCK_50);
            if (joy_valid === 1'b1) begin
                seen = 1'b1;
                t    = cyc;
            end
        end
    endtask

    task automatic test_reset();
        int first_load, first_clk;
        word_h = 16'hFFFF;
        word_l = 16'hFFFF;
        RESET  = 1'b1;
        repeat (5) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        n_checks++;
        if ({JOY_CLK, JOY_LOAD, JOY_SEL} !== 3'b111)
            $display("FAIL reset_pins got %b want 111", {JOY_CLK, JOY_LOAD, JOY_SEL});
        else n_pass++;
        n_checks++;
        if ({joy0, joy1, md0, md1, joy_valid} !== 19'd0)
            $display("FAIL reset_outs got %h want 0", {joy0, joy1, md0, md1, joy_valid});
        else n_pass++;
        sb_q.push_back({8'h00, 8'h00, 1'b0, 1'b0});
        RESET      = 1'b0;
        rel_cyc    = cyc;
        first_load = -1;
        first_clk  = -1;
        for (int n = 1; n <= SD + STL + 2 * CD; n++) begin
            @(negedge CLOCK_50);
            if (first_load < 0 && JOY_LOAD === 1'b0) first_load = n;
            if (first_clk < 0 && JOY_CLK === 1'b0) first_clk = n;
        end
        n_checks++;
        if (first_load != SD + STL)
            $display("FAIL first_load cycle got %0d want %0d", first_load, SD + STL);
        else n_pass++;
        n_checks++;
        if (first_clk != SD + STL + 2 * CD)
            $display("FAIL first_clk cycle got %0d want %0d", first_clk, SD + STL + 2 * CD);
        else n_pass++;
    endtask

    task automatic test_idle();
        bit   seen;
        int   t;
        exp_t e;
        wait_valid(seen, t);
        e = sb_q.pop_front();
        n_checks++;
        if (!seen) begin
            $display("FAIL idle_valid got no pulse want pulse");
            return;
        end
        n_pass++;
        n_checks++;
        if (t - rel_cyc != SD + SCAN_LEN)
            $display("FAIL idle_latency got %0d want %0d", t - rel_cyc, SD + SCAN_LEN);
        else n_pass++;
        n_checks++;
        if ({joy0, joy1, md0, md1} !== e)
            $display("FAIL idle_words got %h want %h", {joy0, joy1, md0, md1}, e);
        else n_pass++;
        @(negedge CLOCK_50);
        n_checks++;
        if (joy_valid !== 1'b0) $display("FAIL idle_pulse_width got %b want 0", joy_valid);
        else n_pass++;
    endtask

    task automatic test_atari();
        bit   seen;
        int   t;
        exp_t e;
        word_h = 16'h77FF;
        word_l = 16'h77FF;
        sb_q.push_back({8'h11, 8'h00, 1'b0, 1'b0});
        wait_valid(seen, t);
        e = sb_q.pop_front();
        n_checks++;
        if (!seen || {joy0, joy1, md0, md1} !== e)
            $display("FAIL atari_up_fire1 got %h (valid %b) want %h", {joy0, joy1, md0, md1},
                     seen, e);
        else n_pass++;
    endtask

    task automatic test_md();
        bit   seen;
        int   t;
        exp_t e;
        logic [15:0] lw [2];
        lw[0] = 16'hFFC7;
        lw[1] = 16'hFFCB;
        for (int i = 0; i < 2; i++) begin
            word_h = 16'hFFFF;
            word_l = lw[i];
            sb_q.push_back({8'h00, (i == 0) ? 8'h04 : 8'h08, 1'b0, 1'b1});
            wait_valid(seen, t);
            e = sb_q.pop_front();
            n_checks++;
            if (!seen || {joy0, joy1, md0, md1} !== e)
                $display("FAIL md_port1[%0d] got %h (valid %b) want %h", i,
                         {joy0, joy1, md0, md1}, seen, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_scan();
        bit   seen, synced;
        int   t, loads, rises;
        logic prev_load, prev_clk;
        exp_t e;
        word_h    = 16'h77FF;
        word_l    = 16'hFFC7;
        loads     = 0;
        rises     = 0;
        synced    = 1'b0;
        prev_load = JOY_LOAD;
        prev_clk  = JOY_CLK;
        for (int n = 0; n < BUDGET && !synced; n++) begin
            @(negedge CLOCK_50);
            if (prev_load && !JOY_LOAD) loads++;
            if (loads == 2 && !prev_clk && JOY_CLK) rises++;
            if (rises == 7) synced = 1'b1;
            prev_load = JOY_LOAD;
            prev_clk  = JOY_CLK;
        end
        n_checks++;
        if (!synced) $display("FAIL mid_sync got no phase-1 bit 6 want reached");
        else n_pass++;
        repeat (CD + 1) @(negedge CLOCK_50);
        n_checks++;
        if ({JOY_SEL, JOY_CLK} !== 2'b00)
            $display("FAIL mid_phase1_low got sel/clk %b want 00", {JOY_SEL, JOY_CLK});
        else n_pass++;
        RESET = 1'b1;
        @(negedge CLOCK_50);
        n_checks++;
        if ({JOY_CLK, JOY_LOAD, JOY_SEL} !== 3'b111)
            $display("FAIL mid_reset_pins got %b want 111", {JOY_CLK, JOY_LOAD, JOY_SEL});
        else n_pass++;
        n_checks++;
        if ({joy0, joy1, md0, md1, joy_valid} !== 19'd0)
            $display("FAIL mid_reset_outs got %h want 0", {joy0, joy1, md0, md1, joy_valid});
        else n_pass++;
        repeat (2) @(negedge CLOCK_50);
        RESET   = 1'b0;
        rel_cyc = cyc;
        sb_q.push_back({8'h11, 8'h04, 1'b0, 1'b1});
        wait_valid(seen, t);
        e = sb_q.pop_front();
        n_checks++;
        if (!seen || t - rel_cyc != SD + SCAN_LEN)
            $display("FAIL mid_latency got %0d (valid %b) want %0d", t - rel_cyc, seen,
                     SD + SCAN_LEN);
        else n_pass++;
        n_checks++;
        if ({joy0, joy1, md0, md1} !== e)
            $display("FAIL mid_words got %h want %h", {joy0, joy1, md0, md1}, e);
        else n_pass++;
    endtask

    task automatic test_waveform();
        bit   seen;
        int   loads, last_rise, bad_space, sel_fall;
        int   rises[2], load_len[2], load_fall[2];
        logic sel_at_load[2];
        logic prev_load, prev_clk, prev_sel;
        exp_t e;
        word_h = 16'hFFFF;
        word_l = 16'hFFFF;
        sb_q.push_back({8'h00, 8'h00, 1'b0, 1'b0});
        seen = 1'b0;
        loads = 0;
        last_rise = -1;
        bad_space = 0;
        sel_fall = -1;
        for (int k = 0; k < 2; k++) begin
            rises[k] = 0;
            load_len[k] = 0;
            load_fall[k] = -1;
            sel_at_load[k] = 1'bx;
        end
        prev_load = JOY_LOAD;
        prev_clk  = JOY_CLK;
        prev_sel  = JOY_SEL;
        for (int n = 0; n < BUDGET && !seen; n++) begin
            @(negedge CLOCK_50);
            if (prev_load && !JOY_LOAD && loads < 2) begin
                load_fall[loads]   = n;
                sel_at_load[loads] = JOY_SEL;
                loads++;
                last_rise = -1;
            end
            if (!JOY_LOAD && loads > 0) load_len[loads-1]++;
            if (!prev_clk && JOY_CLK && loads > 0) begin
                rises[loads-1]++;
                if (last_rise >= 0 && n - last_rise != 2 * CD) bad_space++;
                last_rise = n;
            end
            if (prev_sel && !JOY_SEL) sel_fall = n;
            if (joy_valid === 1'b1) seen = 1'b1;
            prev_load = JOY_LOAD;
            prev_clk  = JOY_CLK;
            prev_sel  = JOY_SEL;
        end
        e = sb_q.pop_front();
        n_checks++;
        if (!seen) begin
            $display("FAIL wave_valid got no pulse want pulse");
            return;
        end
        n_pass++;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (rises[k] != 16) $display("FAIL wave_rises[%0d] got %0d want 16", k, rises[k]);
            else n_pass++;
            n_checks++;
            if (load_len[k] != 2 * CD)
                $display("FAIL wave_load_len[%0d] got %0d want %0d", k, load_len[k], 2 * CD);
            else n_pass++;
        end
        n_checks++;
        if (bad_space != 0) $display("FAIL wave_clk_spacing got %0d bad want 0", bad_space);
        else n_pass++;
        n_checks++;
        if ({sel_at_load[0], sel_at_load[1]} !== 2'b10)
            $display("FAIL wave_sel_at_load got %b want 10", {sel_at_load[0], sel_at_load[1]});
        else n_pass++;
        n_checks++;
        if (load_fall[1] - sel_fall != STL)
            $display("FAIL wave_sel_settle got %0d want %0d", load_fall[1] - sel_fall, STL);
        else n_pass++;
        n_checks++;
        if (load_fall[1] - load_fall[0] != PH)
            $display("FAIL wave_phase_len got %0d want %0d", load_fall[1] - load_fall[0], PH);
        else n_pass++;
        n_checks++;
        if (JOY_SEL !== 1'b1 || {joy0, joy1, md0, md1} !== e)
            $display("FAIL wave_end got sel %b words %h want 1 %h", JOY_SEL,
                     {joy0, joy1, md0, md1}, e);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit   seen;
        int   t;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            word_h = 16'($urandom);
            word_l = 16'($urandom);
            if (i == 0) word_l = 16'hC3C3;
            push_model();
            wait_valid(seen, t);
            e = sb_q.pop_front();
            n_checks++;
            if (!seen || {joy0, joy1, md0, md1} !== e)
                $display("FAIL b2b[%0d] h=%h l=%h got %h (valid %b) want %h", i, word_h, word_l,
                         {joy0, joy1, md0, md1}, seen, e);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_atari();
        test_md();
        test_reset_mid_scan();
        test_waveform();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
